// File: rtl/imem_load_ctrl_if.sv
// Bus bundle for imem_load_ctrl: loader word stream, CPU fetch port and
// single-port instruction-memory bus. slave = controller side.
interface imem_load_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic [31:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_ins;
  logic              cpu_stall;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ld_valid, ld_data, ld_last, cpu_addr, mem_rdata,
    output ld_ready, cpu_ins, cpu_stall, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ld_valid, ld_data, ld_last, cpu_addr, mem_rdata,
    input  ld_ready, cpu_ins, cpu_stall, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: streams a program into IMEM, then hands
// the memory to the CPU fetch port. Optional fetch bounds check: IMEM_BOUNDS_CHK_EN.
//
// state | meaning
// IDLE  | no program resident, waiting for load_start
// LOAD  | accepting loader words, CPU stalled
// DRAIN | last word's registered write completes
// RUN   | program resident, CPU owns the memory
// ERR   | program exceeded MAX_WORDS, waiting for reload
module imem_load_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_start_i,
  imem_load_ctrl_if.slave bus,
  output logic [ADDR_W:0] word_count_o,
  output logic            load_done_o,
  output logic            overflow_err_o,
  output logic            fetch_fault_o
);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RUN, ERR} state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MAX_WORDS - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  state_t            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              mem_we_q;
  logic              ovf_q;
  logic [ADDR_W:0]   word_count_q;
  logic              hs;
  logic              in_run;
  logic              fault;

  assign in_run = (state_q == RUN);
  assign hs     = bus.ld_valid && (state_q == LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      mem_we_q     <= 1'b0;
      ovf_q        <= 1'b0;
      word_count_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE, RUN, ERR: begin
          if (load_start_i) begin
            state_q      <= LOAD;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            ovf_q        <= 1'b0;
          end
        end
        LOAD: begin
          if (hs) begin
            mem_we_q     <= 1'b1;
            wr_addr_q    <= wr_ptr_q;
            wr_data_q    <= bus.ld_data;
            wr_ptr_q     <= wr_ptr_q + PTR_ONE;
            word_count_q <= word_count_q + CNT_ONE;
            // ld_last on the final permitted word is a legal full-size program
            if (bus.ld_last) begin
              state_q <= DRAIN;
            end else if (wr_ptr_q == LAST_PTR) begin
              state_q <= ERR;
              ovf_q   <= 1'b1;
            end
          end
        end
        DRAIN:   state_q <= RUN;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IMEM_BOUNDS_CHK_EN
  assign fault = in_run &&
                 (({1'b0, bus.cpu_addr[ADDR_W-1:0]} >= word_count_q) ||
                  (|bus.cpu_addr[31:ADDR_W]));
`else
  logic unused_cpu_addr_hi;
  assign unused_cpu_addr_hi = ^bus.cpu_addr[31:ADDR_W];
  assign fault = 1'b0;
`endif

  assign bus.ld_ready   = (state_q == LOAD);
  assign bus.cpu_stall  = !in_run;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = wr_data_q;
  assign bus.mem_addr   = in_run ? bus.cpu_addr[ADDR_W-1:0] : wr_addr_q;
  assign bus.cpu_ins    = (in_run && !fault) ? bus.mem_rdata : '0;
  assign word_count_o   = word_count_q;
  assign load_done_o    = in_run;
  assign overflow_err_o = ovf_q;
  assign fetch_fault_o  = fault;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Testbench for imem_load_ctrl: memory model plus write scoreboard (expected
// {addr,data} queued on each handshake, popped when mem_we is seen).
module tb_imem_load_ctrl;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int MAXW   = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            load_start;
  logic [ADDR_W:0] word_count;
  logic            load_done, overflow_err, fetch_fault;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] exp_ptr;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mem[16];

  imem_load_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_load_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .load_start_i(load_start), .bus(bus),
    .word_count_o(word_count), .load_done_o(load_done),
    .overflow_err_o(overflow_err), .fetch_fault_o(fetch_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h", bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== e) begin
          errors++;
          $display("FAIL write got addr=%0d data=%h exp addr=%0d data=%h",
                   bus.mem_addr, bus.mem_wdata, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1; tick(); load_start = 1'b0; exp_ptr = '0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic last);
    bus.ld_valid = 1'b1; bus.ld_data = d; bus.ld_last = last;
    @(negedge clk);
    if (bus.ld_ready === 1'b1) begin
      exp_q.push_back({exp_ptr, d});
      exp_ptr = exp_ptr + 1'b1;
    end
    tick();
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_start = 1'b0; exp_ptr = '0;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0; bus.cpu_addr = '0;
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL rst_stall got=%b exp=1", bus.cpu_stall); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", bus.ld_ready); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL rst_addr got=%0d exp=0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== '0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", bus.mem_wdata); end
    checks++; if (word_count !== '0) begin errors++; $display("FAIL rst_count got=%0d exp=0", word_count); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", load_done); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", overflow_err); end
    checks++; if (bus.cpu_ins !== '0) begin errors++; $display("FAIL rst_ins got=%h exp=0", bus.cpu_ins); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got=%b exp=0", fetch_fault); end
    // loader activity in IDLE must be refused
    for (int i = 0; i < 3; i++) send_word(32'h1111_0000 + i, 1'b0);
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got=%b exp=0", bus.ld_ready); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL idle_accept got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_load_back_to_back();
    pulse_start();
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready got=%b exp=1", bus.ld_ready); end
    for (int i = 0; i < 6; i++) send_word(32'hA000_0000 + i, (i == 5));
    checks++; if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL drain_stall got=%b exp=1", bus.cpu_stall); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL drain_ready got=%b exp=0", bus.ld_ready); end
    tick();
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL run_stall got=%b exp=0", bus.cpu_stall); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL run_done got=%b exp=1", load_done); end
    checks++; if (word_count !== 5'd6) begin errors++; $display("FAIL load6_count got=%0d exp=6", word_count); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL load6_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_fetch();
    bus.cpu_addr = 32'd3; #1;
    checks++; if (bus.mem_addr !== 4'd3) begin errors++; $display("FAIL fetch_addr got=%0d exp=3", bus.mem_addr); end
    checks++; if (bus.cpu_ins !== 32'hA000_0003) begin errors++; $display("FAIL fetch3 got=%h exp=a0000003", bus.cpu_ins); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL fetch3_fault got=%b exp=0", fetch_fault); end
    bus.cpu_addr = 32'd5; #1;
    checks++; if (bus.cpu_ins !== 32'hA000_0005) begin errors++; $display("FAIL fetch5 got=%h exp=a0000005", bus.cpu_ins); end
    bus.cpu_addr = 32'd7; #1;
`ifdef IMEM_BOUNDS_CHK_EN
    checks++; if (bus.cpu_ins !== '0) begin errors++; $display("FAIL fetch7 got=%h exp=0", bus.cpu_ins); end
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fetch7_fault got=%b exp=1", fetch_fault); end
`else
    checks++; if (bus.cpu_ins !== 32'hDEAD_0007) begin errors++; $display("FAIL fetch7 got=%h exp=dead0007", bus.cpu_ins); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL fetch7_fault got=%b exp=0", fetch_fault); end
`endif
    bus.cpu_addr = 32'h13; #1;
    checks++; if (bus.mem_addr !== 4'd3) begin errors++; $display("FAIL fetch_hi_addr got=%0d exp=3", bus.mem_addr); end
`ifdef IMEM_BOUNDS_CHK_EN
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fetch_hi_fault got=%b exp=1", fetch_fault); end
`else
    checks++; if (bus.cpu_ins !== 32'hA000_0003) begin errors++; $display("FAIL fetch_hi got=%h exp=a0000003", bus.cpu_ins); end
`endif
    bus.cpu_addr = '0;
    send_word(32'h2222_2222, 1'b0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL run_accept got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_gaps();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send_word(32'hB000_0000 + i, (i == 3));
      if (i < 3) tick();
    end
    tick();
    checks++; if (word_count !== 5'd4) begin errors++; $display("FAIL gap_count got=%0d exp=4", word_count); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL gap_stall got=%b exp=0", bus.cpu_stall); end
    bus.cpu_addr = 32'd2; #1;
    checks++; if (bus.cpu_ins !== 32'hB000_0002) begin errors++; $display("FAIL gap_fetch got=%h exp=b0000002", bus.cpu_ins); end
    bus.cpu_addr = '0;
  endtask

  task automatic test_overflow();
    pulse_start();
    for (int i = 0; i < MAXW; i++) send_word(32'hC000_0000 + i, 1'b0);
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow_err); end
    checks++; if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL ovf_stall got=%b exp=1", bus.cpu_stall); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL ovf_done got=%b exp=0", load_done); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got=%b exp=0", bus.ld_ready); end
    checks++; if (word_count !== 5'd6) begin errors++; $display("FAIL ovf_count got=%0d exp=6", word_count); end
    send_word(32'h3333_3333, 1'b1);
    tick();
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_hold got=%b exp=1", overflow_err); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_pending got=%0d exp=0", exp_q.size()); end
    pulse_start();
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow_err); end
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL ovf_reload_ready got=%b exp=1", bus.ld_ready); end
    send_word(32'hD000_0000, 1'b1);
    tick();
    checks++; if (word_count !== 5'd1) begin errors++; $display("FAIL ovf_reload_count got=%0d exp=1", word_count); end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    send_word(32'hE000_0000, 1'b0);
    send_word(32'hE000_0001, 1'b0);
    bus.ld_valid = 1'b1; bus.ld_data = 32'hE000_0002;
    rst_n = 1'b0; #1;
    exp_q.delete();
    checks++; if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL mid_stall got=%b exp=1", bus.cpu_stall); end
    checks++; if (word_count !== '0) begin errors++; $display("FAIL mid_count got=%0d exp=0", word_count); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL mid_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got=%b exp=0", bus.ld_ready); end
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    bus.ld_valid = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) send_word(32'hF000_0000 + i, (i == 2));
    tick();
    checks++; if (word_count !== 5'd3) begin errors++; $display("FAIL mid_reload_count got=%0d exp=3", word_count); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL mid_reload_done got=%b exp=1", load_done); end
  endtask

  task automatic test_reload_from_run();
    pulse_start();
    checks++; if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL reload_stall got=%b exp=1", bus.cpu_stall); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reload_done got=%b exp=0", load_done); end
    checks++; if (word_count !== '0) begin errors++; $display("FAIL reload_count got=%0d exp=0", word_count); end
    send_word(32'h7000_0000, 1'b0);
    send_word(32'h7000_0001, 1'b0);
    load_start = 1'b1; tick(); load_start = 1'b0;
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL restart_ready got=%b exp=1", bus.ld_ready); end
    checks++; if (word_count !== 5'd2) begin errors++; $display("FAIL restart_count got=%0d exp=2", word_count); end
    send_word(32'h7000_0002, 1'b0);
    send_word(32'h7000_0003, 1'b1);
    tick();
    checks++; if (word_count !== 5'd4) begin errors++; $display("FAIL restart_final got=%0d exp=4", word_count); end
    bus.cpu_addr = 32'd3; #1;
    checks++; if (bus.cpu_ins !== 32'h7000_0003) begin errors++; $display("FAIL restart_fetch got=%h exp=70000003", bus.cpu_ins); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL restart_pending got=%0d exp=0", exp_q.size()); end
    bus.cpu_addr = '0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 + i;
    test_reset();
    test_load_back_to_back();
    test_fetch();
    test_gaps();
    test_overflow();
    test_reset_mid_load();
    test_reload_from_run();
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
